// File: rtl/etc_tile_accum.sv
// Reduction stage after the 4x4 semiring MMA core: folds one partial-product tile
// per K-step into a result tile and hands it off through a one-entry output buffer.
module etc_tile_accum #(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [16*W-1:0]   in_tile,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*W-1:0]   out_tile,
    output logic [CNT_W-1:0]  k_count,
    output logic              seq_err
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [16*W-1:0]    r_acc;
    logic [16*W-1:0]    r_out;
    logic [16*W-1:0]    w_red;
    logic [16*W-1:0]    w_new_acc;
    logic               r_max;
    logic               r_out_valid;
    logic               r_err;
    logic [CNT_W-1:0]   r_k;
    logic               w_accept;
    logic               w_start;
    logic               w_bad_seq;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    // A tile starts a fresh reduction whenever nothing is pending or it is flagged first.
    assign w_start   = (r_state == IDLE) || in_first;
    assign w_bad_seq = (r_state == IDLE) ? !in_first : in_first;

    assign out_valid = r_out_valid;
    assign out_tile  = r_out;
    assign k_count   = r_k;
    assign seq_err   = r_err;

    always_comb begin
        w_red = '0;
        for (int e = 0; e < 16; e++) begin
            if (r_max)
                w_red[e*W +: W] = (r_acc[e*W +: W] > in_tile[e*W +: W]) ?
                                  r_acc[e*W +: W] : in_tile[e*W +: W];
            else
                w_red[e*W +: W] = r_acc[e*W +: W] + in_tile[e*W +: W];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_new_acc    = w_start ? in_tile : w_red;
        if (w_accept)
            w_next_state = in_last ? IDLE : ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out       <= '0;
            r_max       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_k         <= '0;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            if (w_accept) begin
                r_acc <= w_new_acc;
                if (w_bad_seq)
                    r_err <= 1'b1;
                if (w_start) begin
                    r_max <= (op != 2'd0);
                    r_k   <= CNT_W'(1);
                end else if (r_k != {CNT_W{1'b1}}) begin
                    r_k   <= r_k + CNT_W'(1);
                end
                // A new result overrides the drain above, so back-to-back results have no bubble.
                if (in_last) begin
                    r_out       <= w_new_acc;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_etc_tile_accum.sv
// Directed bench for etc_tile_accum: stimulus pushes expected results into a
// queue that an independent monitor pops whenever a result is handed off.
module tb_etc_tile_accum;

    localparam int W     = 16;
    localparam int CNT_W = 8;
    localparam int TW    = 16 * W;

    typedef struct {
        logic [TW-1:0]    tile;
        logic [CNT_W-1:0] k;
        logic             err;
    } expect_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        op = 2'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [TW-1:0]     in_tile = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [TW-1:0]     out_tile;
    logic [CNT_W-1:0]  k_count;
    logic              seq_err;

    expect_t scoreboard[$];
    int      nChecks = 0;
    int      nErrors = 0;

    etc_tile_accum #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .in_tile(in_tile),
        .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile),
        .k_count(k_count), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] fill(input logic [W-1:0] v);
        logic [TW-1:0] t;
        for (int e = 0; e < 16; e++) t[e*W +: W] = v;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [TW-1:0] actual,
                               input logic [TW-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [TW-1:0] tile, input int k, input logic err);
        expect_t e;
        e.tile = tile;
        e.k    = CNT_W'(k);
        e.err  = err;
        scoreboard.push_back(e);
    endtask

    // Presents one tile and returns one time unit after the edge that accepted it.
    task automatic applyStimulus(input logic first, input logic last,
                                 input logic [1:0] opv, input logic [TW-1:0] tile);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        op       = opv;
        in_tile  = tile;
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every handshake at the coming edge is compared against the queue head.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (scoreboard.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL unexpected_out: got %0h, expected no result", out_tile);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("out_tile", out_tile, e.tile);
                    checkOutput("k_count", TW'(k_count), TW'(e.k));
                    checkOutput("seq_err", TW'(seq_err), TW'(e.err));
                end
            end
        end
    end

    initial begin
        logic [TW-1:0] tileA, tileB, tileMax, tileSingle, held;
        int drainWait;

        for (int e = 0; e < 16; e++) begin
            tileA[e*W +: W]      = W'(e);
            tileB[e*W +: W]      = W'(15 - e);
            tileMax[e*W +: W]    = (e > 15 - e) ? W'(e) : W'(15 - e);
            tileSingle[e*W +: W] = W'(16'h100 + e);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", TW'(out_valid), '0);
        checkOutput("rst_out_tile", out_tile, '0);
        checkOutput("rst_k_count", TW'(k_count), '0);
        checkOutput("rst_seq_err", TW'(seq_err), '0);

        // Add-reduce 3+5, back-to-back, result visible the next cycle
        pushExpect(fill(16'd8), 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, fill(16'd3));
        applyStimulus(1'b0, 1'b1, 2'd0, fill(16'd5));
        checkOutput("latency_out_valid", TW'(out_valid), TW'(1));

        // Max-reduce with op latched on the first tile; op changes on the last tile are ignored
        pushExpect(tileMax, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd1, tileA);
        applyStimulus(1'b0, 1'b1, 2'd0, tileB);

        // Add-reduce wraps modulo 2^W
        pushExpect(fill(16'h0001), 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, fill(16'hFFFF));
        applyStimulus(1'b0, 1'b1, 2'd3, fill(16'h0002));

        // Single-tile sequence followed immediately by another one
        pushExpect(tileSingle, 1, 1'b0);
        pushExpect(fill(16'h00AA), 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, tileSingle);
        applyStimulus(1'b1, 1'b1, 2'd0, fill(16'h00AA));

        // Backpressure: stalled result blocks input and holds steady
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        pushExpect(fill(16'd3), 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, fill(16'd1));
        applyStimulus(1'b0, 1'b1, 2'd0, fill(16'd2));
        held = out_tile;
        pushExpect(fill(16'd6), 1, 1'b0);
        in_valid = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b1;
        op       = 2'd0;
        in_tile  = fill(16'd6);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", TW'(in_ready), '0);
            checkOutput("stall_out_tile", out_tile, held);
        end
        checkOutput("stall_out_valid", TW'(out_valid), TW'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain_in_ready", TW'(in_ready), TW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("b2b_out_valid", TW'(out_valid), TW'(1));
        checkOutput("b2b_out_tile", out_tile, fill(16'd6));

        // Sequencing errors: restart mid-sequence, then a tile without first in IDLE
        pushExpect(fill(16'd9), 2, 1'b1);
        pushExpect(fill(16'd5), 1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd0, fill(16'd1));
        applyStimulus(1'b1, 1'b0, 2'd0, fill(16'd7));
        applyStimulus(1'b0, 1'b1, 2'd0, fill(16'd2));
        applyStimulus(1'b0, 1'b1, 2'd0, fill(16'd5));

        // Reset mid-sequence discards the partial result and sticky flag
        applyStimulus(1'b1, 1'b0, 2'd0, fill(16'd1));
        applyStimulus(1'b0, 1'b0, 2'd0, fill(16'd1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst2_out_valid", TW'(out_valid), '0);
        checkOutput("rst2_out_tile", out_tile, '0);
        checkOutput("rst2_k_count", TW'(k_count), '0);
        checkOutput("rst2_seq_err", TW'(seq_err), '0);
        pushExpect(fill(16'd4), 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, fill(16'd4));

        // Let the monitor consume everything still expected
        drainWait = 0;
        while (scoreboard.size() != 0 && drainWait < 50) begin
            @(posedge clk);
            drainWait++;
        end
        repeat (2) @(posedge clk);
        nChecks++;
        if (scoreboard.size() != 0) begin
            nErrors++;
            $display("[TB] FAIL missing_results: got %0d pending, expected 0", scoreboard.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/etc_tile_accum.md
Name: etc_tile_accum

Overview:
- Downstream stage of the Extended Tensor Core 4x4 semiring MMA unit.
- Consumes the core's 4x4 partial-product tiles, one per K-step, and reduces them into a single result tile.
- Reduction uses the same semiring as the core: plus for MMA (op==0), max for MaxPlus (op!=0).
- Presents the finished tile to the writeback side through a valid/ready handshake with a one-entry output buffer.

Parameters:
- W, 16: element width in bits; matches core W.
- CNT_W, 8: width of the K-step tile counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- op  input  2  semiring select, sampled on the first tile of a sequence. 0 = add-reduce; any other value = max-reduce.
- in_valid  input  1  in_tile/in_first/in_last are valid.
- in_ready  output  1  block can accept a tile this cycle.
- in_first  input  1  tile starts a new reduction.
- in_last  input  1  tile ends the reduction.
- in_tile  input  16*W  core output tile. Element (r,c) is at bits [(r*4+c)*W +: W].
- out_valid  output  1  out_tile holds a completed result.
- out_ready  input  1  consumer accepts out_tile.
- out_tile  output  16*W  reduced tile; same packing as in_tile.
- k_count  output  CNT_W  tiles accepted in the current or most recent sequence; saturates at 2^CNT_W-1.
- seq_err  output  1  sticky flag for sequencing errors; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state:
  - out_valid=0, out_tile=0, k_count=0, seq_err=0.
  - Internal accumulator=0, latched op=0, state=IDLE.
  - Reset mid-sequence discards the partial result.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Nothing changes on a cycle without accept, except output drain.
- Reduce function f(a,b), per element, unsigned W-bit:
  - latched op==0: (a+b) mod 2^W, wraps, no saturation.
  - latched op!=0: max(a,b).
- States: IDLE (no partial result) and ACCUM (partial result held).
- IDLE, accept:
  - Tile loads the accumulator; op is latched; k_count=1.
  - in_last=1: out_tile<=in_tile, out_valid<=1, stay IDLE.
  - Otherwise go to ACCUM.
  - If in_first=0, the tile is still treated as a first tile and seq_err<=1.
- ACCUM, accept with in_first=0:
  - accumulator<=f(accumulator,in_tile); k_count increments (saturating).
  - in_last=1: out_tile<=f(accumulator,in_tile), out_valid<=1, go to IDLE.
- ACCUM, accept with in_first=1:
  - Partial result is discarded and seq_err<=1.
  - The tile is handled as a first tile in IDLE, including the first+last case.
- Latency: out_valid rises on the cycle after the last tile is accepted.
- op changes after the first tile have no effect until the next first tile.
- Output handshake:
  - out_valid && out_ready at an edge drains the buffer; out_valid<=0 unless a new result is written in the same cycle.
  - Simultaneous drain and new result: out_valid stays 1 and out_tile takes the new value, giving back-to-back results with no bubble.
  - While out_valid && !out_ready: in_ready=0, and out_tile/out_valid hold stable.
- k_count holds its value in IDLE until the next first tile.
- Throughput: one tile per cycle when the output is not stalled.

Test Plan:
- Add-reduce (W=16, op=0): tiles all-3 (first), then all-5 (last), back-to-back → next cycle out_valid=1, every element 8, k_count=2, seq_err=0.
- Max-reduce wrap/compare (op=1): tile A element=r*4+c (first), tile B element=15-(r*4+c) (last) → (0,0)=15, (1,2)=9, (3,3)=15. Repeat with op=0 and elements 0xFFFF + 0x0002 → every element 0x0001.
- Single-tile sequence: first+last tile with element (r,c)=0x100+r*4+c → out_tile equals the input next cycle; state remains IDLE; a new first tile is accepted the following cycle.
- Backpressure:
  - Complete a sequence with out_ready=0 → out_valid=1, in_ready=0. A pending tile with in_valid=1 is not accepted and out_tile stays stable for 5 cycles.
  - Raise out_ready → drain; the pending tile is accepted the same cycle.
  - Simultaneous drain and new last tile → out_valid stays 1 with the new value.
- Sequencing errors:
  - First tile all-1, then first tile all-7 followed by last tile all-2 with op=0 → out all-9, k_count=2, seq_err=1.
  - Tile without in_first in IDLE → seq_err=1, tile treated as first.
- Reset mid-operation: rst=1 for 1 cycle after two accumulated tiles → out_valid=0, out_tile=0, k_count=0, seq_err=0. A fresh first+last all-4 tile → out all-4 with no residue from before.
